secuenciador_instr: RTL
=======================

# secuenciador_instr

Instruction sequencer that drives the 20-bit instruction word into the datapath (register bank A, ALU, memory B) and reads back its 32-bit result bus. It holds a small loadable program memory. On a start pulse it issues one instruction per clock from address 0 until a programmed last address or a halt word. It captures the datapath result on every instruction that reads or writes memory B. It is the producer/consumer end of the datapath's INSTRUCCION/RESULTADO interface.

## Interface
- ANCHO_INSTR, 20: instruction width; field layout MC[19:18], OP1[17:13], ALUC[12:10], OP2[9:5], MB[4:0].
- ANCHO_DATO, 32: datapath result width.
- ANCHO_DIR, 5: program address width; depth 2^ANCHO_DIR = 32 words.

Ports:
- CLK  in  1  single clock; all state changes on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- CARGA_EN  in  1  program write strobe.
- CARGA_DIR  in  ANCHO_DIR  program write address.
- CARGA_DATO  in  ANCHO_INSTR  program write data.
- INICIO  in  1  start pulse.
- ULTIMA_DIR  in  ANCHO_DIR  last address to execute; latched at start.
- RESULTADO  in  ANCHO_DATO  datapath result bus (combinational from INSTRUCCION).
- INSTRUCCION  out  ANCHO_INSTR  registered instruction to the datapath.
- RESULTADO_CAPT  out  ANCHO_DATO  last captured result.
- CAPTURA  out  1  one-cycle pulse when RESULTADO_CAPT updates.
- OCUPADO  out  1  high while executing.
- LISTO  out  1  one-cycle pulse on completion.
- CONTADOR  out  ANCHO_DIR+1  instructions issued in the current/last run.

## Operation
- Program memory is 2^ANCHO_DIR x ANCHO_INSTR and is not cleared by reset.
- NOP = 20'h00000 (MC=00: no register or memory write). Halt word = any word with MC=11; it is never issued.
- States: IDLE, EJECUTA, FIN.
- IDLE:
  - INSTRUCCION=NOP, OCUPADO=0.
  - CARGA_EN=1 writes CARGA_DATO to mem[CARGA_DIR]. CARGA_EN is ignored outside IDLE.
  - INICIO=1 with CARGA_EN=0 latches ULTIMA_DIR and clears CONTADOR.
    - If mem[0] is a halt word: INSTRUCCION stays NOP and the state goes to FIN.
    - Otherwise: INSTRUCCION<=mem[0], DIR_ACTUAL<=0, CONTADOR<=1, state goes to EJECUTA.
  - CARGA_EN and INICIO together: the write is performed and INICIO is ignored.
- EJECUTA (OCUPADO=1), actions at each edge:
  - Capture: if INSTRUCCION MC is 00 or 10, RESULTADO_CAPT<=RESULTADO and CAPTURA=1 next cycle. MC=01 is not captured.
  - If DIR_ACTUAL==latched ULTIMA_DIR, or DIR_ACTUAL==2^ANCHO_DIR-1, or mem[DIR_ACTUAL+1] is a halt word: INSTRUCCION<=NOP and the state goes to FIN. The address never wraps.
  - Otherwise: INSTRUCCION<=mem[DIR_ACTUAL+1], DIR_ACTUAL increments, CONTADOR increments.
- FIN lasts one cycle: LISTO=1, OCUPADO=0, INSTRUCCION=NOP, then IDLE. INICIO is ignored in EJECUTA and FIN.
- CONTADOR and RESULTADO_CAPT hold their values from the end of a run until the next start.
- A ULTIMA_DIR value below the halt position ends the run at ULTIMA_DIR.

## Timing
- Reset values: state IDLE, INSTRUCCION=NOP, RESULTADO_CAPT=0, CAPTURA=0, OCUPADO=0, LISTO=0, CONTADOR=0, DIR_ACTUAL=0.
- Reset asserted mid-run: INSTRUCCION returns to NOP immediately. There is no LISTO pulse, and program contents are retained.
- INICIO sampled at edge n:
  - mem[k] is driven on INSTRUCCION during cycle n+1+k.
  - Its result is captured at the edge closing that cycle, so CAPTURA is high in cycle n+2+k.
- Run of N issued instructions: OCUPADO is high for cycles n+1 to n+N, and LISTO is high in cycle n+N+1.
- Halt at address 0: LISTO is high in cycle n+1, OCUPADO never rises, CONTADOR=0.
- All outputs are registered. RESULTADO is assumed settled within the cycle the instruction is driven.

## Test plan
- Load mem[0]=20'b10_00001_000_00010_00011 and mem[1]=20'b00_00000_000_00000_00011, set ULTIMA_DIR=1, pulse INICIO, with the bench modelling RESULTADO=32'hDEADBEEF for MB=3 -> two CAPTURA pulses, RESULTADO_CAPT=32'hDEADBEEF, CONTADOR=2, OCUPADO high for exactly 2 cycles, then LISTO.
- Load mem[0..2] with MC=01 words, mem[3]=halt, ULTIMA_DIR=31 -> 3 instructions issued, no CAPTURA, LISTO one cycle after the third instruction, CONTADOR=3.
- mem[0]=halt, pulse INICIO -> LISTO in the next cycle, OCUPADO stays 0, CONTADOR=0, INSTRUCCION=NOP throughout.
- Fill all 32 words with MC=00, no halt, ULTIMA_DIR=31 -> 32 issues, no wrap to address 0, CONTADOR=32.
- Assert RESET_N=0 during cycle 3 of a 10-instruction run -> INSTRUCCION=NOP, OCUPADO=0 and CONTADOR=0 at once, no LISTO. A re-run after reset reproduces the identical sequence.
- Assert CARGA_EN together with INICIO in IDLE, and pulse INICIO during EJECUTA -> the write lands and no run starts; the second INICIO is ignored (single LISTO, CONTADOR unchanged).

Source files
------------

// File: rtl/secuenciador_instr_if.sv
// Datapath instruction/result link.
//   INSTRUCCION : instruction word driven by the sequencer into the datapath
//   RESULTADO   : datapath result bus, combinational from INSTRUCCION
interface secuenciador_instr_if #(
  parameter int unsigned ANCHO_INSTR = 20,
  parameter int unsigned ANCHO_DATO  = 32
);
  logic [ANCHO_INSTR-1:0] INSTRUCCION;
  logic [ANCHO_DATO-1:0]  RESULTADO;

  // Sequencer end: produces instructions, consumes results
  modport master (output INSTRUCCION, input RESULTADO);
  // Datapath end
  modport slave  (input INSTRUCCION, output RESULTADO);
endinterface

// File: rtl/secuenciador_instr.sv
// Instruction sequencer: loadable program memory, issues one instruction per
// clock from address 0 until the latched last address, the top address or a
// halt word (MC=11), and captures the datapath result for MC=00/10 words.
// Ports:
//   CLK, RESET_N            clock, async active-low reset
//   CARGA_EN/DIR/DATO       program write port (honoured in IDLE only)
//   INICIO, ULTIMA_DIR      start pulse, last address (latched at start)
//   bus                     INSTRUCCION out / RESULTADO in
//   RESULTADO_CAPT, CAPTURA last captured result, one-cycle capture pulse
//   OCUPADO, LISTO          executing flag, one-cycle completion pulse
//   CONTADOR                instructions issued in the current/last run
module secuenciador_instr #(
  parameter int unsigned ANCHO_INSTR = 20,
  parameter int unsigned ANCHO_DATO  = 32,
  parameter int unsigned ANCHO_DIR   = 5
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   CARGA_EN,
  input  logic [ANCHO_DIR-1:0]   CARGA_DIR,
  input  logic [ANCHO_INSTR-1:0] CARGA_DATO,
  input  logic                   INICIO,
  input  logic [ANCHO_DIR-1:0]   ULTIMA_DIR,
  secuenciador_instr_if.master   bus,
  output logic [ANCHO_DATO-1:0]  RESULTADO_CAPT,
  output logic                   CAPTURA,
  output logic                   OCUPADO,
  output logic                   LISTO,
  output logic [ANCHO_DIR:0]     CONTADOR
);

  localparam int unsigned PROF      = 1 << ANCHO_DIR;
  localparam int unsigned ANCHO_CNT = ANCHO_DIR + 1;
  localparam logic [ANCHO_DIR-1:0]   DIR_MAX = '1;
  localparam logic [ANCHO_INSTR-1:0] NOP     = '0;
  localparam logic [1:0] MC_HALT   = 2'b11;
  localparam logic [1:0] MC_SOLO_A = 2'b01;

  typedef enum logic [1:0] {IDLE, EJECUTA, FIN} estado_t;

  estado_t                estado_q, estado_d;
  logic [ANCHO_INSTR-1:0] instr_q, instr_d;
  logic [ANCHO_DIR-1:0]   dir_q, dir_d;
  logic [ANCHO_DIR-1:0]   ultima_q, ultima_d;
  logic [ANCHO_CNT-1:0]   cnt_q, cnt_d;
  logic [ANCHO_DATO-1:0]  capt_q, capt_d;
  logic                   captura_q, captura_d;
  logic                   ocupado_q, ocupado_d;
  logic                   listo_q, listo_d;

  logic [ANCHO_INSTR-1:0] mem [PROF];
  logic [ANCHO_DIR-1:0]   dir_sig;

  function automatic logic es_halt(input logic [ANCHO_INSTR-1:0] w);
    return w[ANCHO_INSTR-1 -: 2] == MC_HALT;
  endfunction

  // Program memory: no reset, contents survive RESET_N
  always_ff @(posedge CLK) begin
    if (estado_q == IDLE && CARGA_EN) mem[CARGA_DIR] <= CARGA_DATO;
  end

  assign dir_sig = dir_q + ANCHO_DIR'(1);

  // State and output registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      estado_q  <= IDLE;
      instr_q   <= NOP;
      dir_q     <= '0;
      ultima_q  <= '0;
      cnt_q     <= '0;
      capt_q    <= '0;
      captura_q <= 1'b0;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      instr_q   <= instr_d;
      dir_q     <= dir_d;
      ultima_q  <= ultima_d;
      cnt_q     <= cnt_d;
      capt_q    <= capt_d;
      captura_q <= captura_d;
      ocupado_q <= ocupado_d;
      listo_q   <= listo_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    estado_d  = estado_q;
    instr_d   = NOP;
    dir_d     = dir_q;
    ultima_d  = ultima_q;
    cnt_d     = cnt_q;
    capt_d    = capt_q;
    captura_d = 1'b0;

    case (estado_q)
      IDLE: begin
        // A simultaneous write wins over the start request
        if (INICIO && !CARGA_EN) begin
          ultima_d = ULTIMA_DIR;
          cnt_d    = '0;
          dir_d    = '0;
          if (es_halt(mem[0])) begin
            estado_d = FIN;
          end else begin
            instr_d  = mem[0];
            cnt_d    = ANCHO_CNT'(1);
            estado_d = EJECUTA;
          end
        end
      end
      EJECUTA: begin
        // Result of the instruction on the bus this cycle; MC=01 writes only bank A
        if (instr_q[ANCHO_INSTR-1 -: 2] != MC_SOLO_A) begin
          capt_d    = bus.RESULTADO;
          captura_d = 1'b1;
        end
        if (dir_q == ultima_q || dir_q == DIR_MAX || es_halt(mem[dir_sig])) begin
          estado_d = FIN;
        end else begin
          instr_d = mem[dir_sig];
          dir_d   = dir_sig;
          cnt_d   = cnt_q + ANCHO_CNT'(1);
        end
      end
      FIN:     estado_d = IDLE;
      default: estado_d = IDLE;
    endcase

    ocupado_d = (estado_d == EJECUTA);
    listo_d   = (estado_d == FIN);
  end

  assign bus.INSTRUCCION = instr_q;
  assign RESULTADO_CAPT  = capt_q;
  assign CAPTURA         = captura_q;
  assign OCUPADO         = ocupado_q;
  assign LISTO           = listo_q;
  assign CONTADOR        = cnt_q;

endmodule
